// File: rtl/pixel_rx_pkg.sv
// rtl/pixel_rx_pkg.sv - shared state type and sizing helpers for the pixel readout receiver
// Contents:
//   rx_state_t     receiver FSM states
//   words_per_row  DATA_OUT words needed to fill one row
//   cnt_width      counter width for a modulus n, never less than 1 bit
package pixel_rx_pkg;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    RECEIVE   = 1'b1
  } rx_state_t;

  function automatic int words_per_row(input int width, input int bus_pixels);
    return width / bus_pixels;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dout_clk_sync.sv
// rtl/dout_clk_sync.sv - DATA_OUT_CLK strobe synchronizer with aligned data capture
// Ports:
//   clk        system clock, rising edge
//   resetn     synchronous active-low reset
//   strobe     asynchronous word strobe
//   data       pixel word, stable around each strobe rise
//   word_evt   one-cycle pulse per strobe rise, two edges after it is first sampled
//   word_data  word aligned with word_evt
module dout_clk_sync #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          strobe,
  input  logic [DW-1:0] data,
  output logic          word_evt,
  output logic [DW-1:0] word_data
);

  logic          s1, s2, s3;
  logic [DW-1:0] d1, d2;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      d1 <= '0;
      d2 <= '0;
    end else begin
      s1 <= strobe;
      s2 <= s1;
      s3 <= s2;
      // data follows the same two stages as the strobe, so d2 is the word that s2 saw
      d1 <= data;
      d2 <= d1;
    end
  end

  assign word_evt  = s2 & ~s3;
  assign word_data = d2;

endmodule

// File: rtl/pixel_readout_receiver.sv
// rtl/pixel_readout_receiver.sv - reassembles DATA_OUT words into rows with a valid/ready output
// Ports:
//   SYSTEM_CLK, SYSTEM_RESET   clock and synchronous active-low reset
//   DATA_OUT_CLK, DATA_OUT     asynchronous word strobe and pixel word
//   FRAME_SYNC                 next word is row 0, col 0
//   ERR_CLEAR                  clears OVERFLOW and FRAME_ERROR
//   ROW_DATA, ROW_INDEX        held row and its row number
//   ROW_VALID, ROW_READY       row handshake
//   FRAME_DONE                 pulse after the last row of a frame is assembled
//   OVERFLOW, FRAME_ERROR      sticky error flags
module pixel_readout_receiver
  import pixel_rx_pkg::*;
#(
  parameter int WIDTH                  = 2,
  parameter int HEIGHT                 = 2,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int BIT_DEPTH              = 8,
  localparam int WORD_W = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH,
  localparam int ROW_W  = WIDTH * BIT_DEPTH,
  localparam int WPR    = words_per_row(WIDTH, OUTPUT_BUS_PIXEL_WIDTH),
  localparam int WC_W   = cnt_width(WPR),
  localparam int RC_W   = cnt_width(HEIGHT)
) (
  input  logic              SYSTEM_CLK,
  input  logic              SYSTEM_RESET,
  input  logic              DATA_OUT_CLK,
  input  logic [WORD_W-1:0] DATA_OUT,
  input  logic              FRAME_SYNC,
  input  logic              ERR_CLEAR,
  output logic [ROW_W-1:0]  ROW_DATA,
  output logic [RC_W-1:0]   ROW_INDEX,
  output logic              ROW_VALID,
  input  logic              ROW_READY,
  output logic              FRAME_DONE,
  output logic              OVERFLOW,
  output logic              FRAME_ERROR
);

  logic              word_evt;
  logic [WORD_W-1:0] word_data;

  dout_clk_sync #(.DW(WORD_W)) u_sync (
    .clk       (SYSTEM_CLK),
    .resetn    (SYSTEM_RESET),
    .strobe    (DATA_OUT_CLK),
    .data      (DATA_OUT),
    .word_evt  (word_evt),
    .word_data (word_data)
  );

  rx_state_t        state_q, state_d;
  logic [WC_W-1:0]  word_cnt, wc_d, wr_word;
  logic [RC_W-1:0]  row_cnt, rc_d, wr_row, done_idx;
  logic [ROW_W-1:0] asm_buf;
  logic             active, wr_en, row_last, frame_last, err_set, row_done;

  // FRAME_SYNC is applied before the word event, so a coincident word lands at row 0, col 0
  always_comb begin
    state_d    = state_q;
    wc_d       = word_cnt;
    rc_d       = row_cnt;
    active     = (state_q == RECEIVE);
    wr_en      = 1'b0;
    wr_word    = '0;
    wr_row     = '0;
    row_last   = 1'b0;
    frame_last = 1'b0;
    err_set    = 1'b0;
    if (FRAME_SYNC) begin
      if (state_q == RECEIVE && (word_cnt != '0 || row_cnt != '0)) err_set = 1'b1;
      state_d = RECEIVE;
      wc_d    = '0;
      rc_d    = '0;
      active  = 1'b1;
    end
    if (word_evt && active) begin
      wr_en   = 1'b1;
      wr_word = wc_d;
      wr_row  = rc_d;
      if (wc_d == WC_W'(WPR - 1)) begin
        row_last = 1'b1;
        wc_d     = '0;
        if (rc_d == RC_W'(HEIGHT - 1)) begin
          frame_last = 1'b1;
          rc_d       = '0;
          state_d    = WAIT_SYNC;
        end else begin
          rc_d = rc_d + RC_W'(1);
        end
      end else begin
        wc_d = wc_d + WC_W'(1);
      end
    end
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (!SYSTEM_RESET) begin
      state_q     <= WAIT_SYNC;
      word_cnt    <= '0;
      row_cnt     <= '0;
      asm_buf     <= '0;
      row_done    <= 1'b0;
      done_idx    <= '0;
      ROW_DATA    <= '0;
      ROW_INDEX   <= '0;
      ROW_VALID   <= 1'b0;
      FRAME_DONE  <= 1'b0;
      OVERFLOW    <= 1'b0;
      FRAME_ERROR <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt   <= wc_d;
      row_cnt    <= rc_d;
      row_done   <= row_last;
      FRAME_DONE <= frame_last;
      if (row_last) done_idx <= wr_row;
      for (int w = 0; w < WPR; w++) begin
        if (wr_en && wr_word == WC_W'(w)) asm_buf[w*WORD_W +: WORD_W] <= word_data;
      end
      // Hold register is free if empty or being drained this very cycle
      if (row_done && (!ROW_VALID || ROW_READY)) begin
        ROW_DATA  <= asm_buf;
        ROW_INDEX <= done_idx;
        ROW_VALID <= 1'b1;
      end else if (ROW_VALID && ROW_READY) begin
        ROW_VALID <= 1'b0;
      end
      // A new error outranks a coincident clear
      if (row_done && ROW_VALID && !ROW_READY) OVERFLOW <= 1'b1;
      else if (ERR_CLEAR)                      OVERFLOW <= 1'b0;
      if (err_set)        FRAME_ERROR <= 1'b1;
      else if (ERR_CLEAR) FRAME_ERROR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_readout_receiver.sv
// tb/tb_pixel_readout_receiver.sv - directed self-checking bench for pixel_readout_receiver
module tb_pixel_readout_receiver;

  logic        clk = 1'b0;
  logic        rstn;
  logic        data_out_clk;
  logic [15:0] data_out;
  logic        frame_sync;
  logic        err_clear;
  logic        row_ready;

  logic [15:0] row_data;
  logic        row_index;
  logic        row_valid, frame_done, overflow, frame_error;
  logic [31:0] row_data2;
  logic        row_index2;
  logic        row_valid2, frame_done2, overflow2, frame_error2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pixel_readout_receiver dut (
    .SYSTEM_CLK(clk), .SYSTEM_RESET(rstn), .DATA_OUT_CLK(data_out_clk), .DATA_OUT(data_out),
    .FRAME_SYNC(frame_sync), .ERR_CLEAR(err_clear), .ROW_DATA(row_data), .ROW_INDEX(row_index),
    .ROW_VALID(row_valid), .ROW_READY(row_ready), .FRAME_DONE(frame_done),
    .OVERFLOW(overflow), .FRAME_ERROR(frame_error)
  );

  pixel_readout_receiver #(.WIDTH(4), .HEIGHT(2), .OUTPUT_BUS_PIXEL_WIDTH(2), .BIT_DEPTH(8)) dut4 (
    .SYSTEM_CLK(clk), .SYSTEM_RESET(rstn), .DATA_OUT_CLK(data_out_clk), .DATA_OUT(data_out),
    .FRAME_SYNC(frame_sync), .ERR_CLEAR(err_clear), .ROW_DATA(row_data2), .ROW_INDEX(row_index2),
    .ROW_VALID(row_valid2), .ROW_READY(row_ready), .FRAME_DONE(frame_done2),
    .OVERFLOW(overflow2), .FRAME_ERROR(frame_error2)
  );

  typedef struct {
    logic        fs;
    logic [15:0] word;
    logic [15:0] exp_data;
    logic        exp_idx;
    logic        exp_fd;
  } vec_t;

  vec_t vecs[4];

  logic        s_v_pre, s_fd_pre, s_v_post, s_idx_post, s_fd_post, s_ovf_post;
  logic [15:0] s_data_post;
  logic        s2_v_post, s2_idx_post;
  logic [31:0] s2_data_post;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  // Strobe rise is first sampled at edge N; snapshots taken after N+2 and N+3
  task automatic send_word(input logic [15:0] w, input int rdy_late);
    data_out = w;
    tick();
    data_out_clk = 1'b1;
    tick(); tick(); tick();
    s_v_pre  = row_valid;
    s_fd_pre = frame_done;
    if (rdy_late >= 0) row_ready = rdy_late[0];
    tick();
    s_v_post     = row_valid;
    s_data_post  = row_data;
    s_idx_post   = row_index;
    s_fd_post    = frame_done;
    s_ovf_post   = overflow;
    s2_v_post    = row_valid2;
    s2_data_post = row_data2;
    s2_idx_post  = row_index2;
    tick();
    data_out_clk = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; data_out_clk = 1'b0; data_out = '0; frame_sync = 1'b0;
    err_clear = 1'b0; row_ready = 1'b1;

    vecs[0] = '{fs: 1'b1, word: 16'hA1B2, exp_data: 16'hA1B2, exp_idx: 1'b0, exp_fd: 1'b0};
    vecs[1] = '{fs: 1'b0, word: 16'hC3D4, exp_data: 16'hC3D4, exp_idx: 1'b1, exp_fd: 1'b1};
    vecs[2] = '{fs: 1'b1, word: 16'h5566, exp_data: 16'h5566, exp_idx: 1'b0, exp_fd: 1'b0};
    vecs[3] = '{fs: 1'b0, word: 16'h7788, exp_data: 16'h7788, exp_idx: 1'b1, exp_fd: 1'b1};

    tick(); tick();
    rstn = 1'b1;
    chk("reset_valid", 64'(row_valid), 64'd0);
    chk("reset_data", 64'(row_data), 64'd0);
    chk("reset_fd", 64'(frame_done), 64'd0);
    chk("reset_ovf", 64'(overflow), 64'd0);
    chk("reset_ferr", 64'(frame_error), 64'd0);

    // Table-driven frames, ROW_READY held high
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].fs) pulse_sync();
      send_word(vecs[i].word, -1);
      chk($sformatf("v%0d_valid_early", i), 64'(s_v_pre), 64'd0);
      chk($sformatf("v%0d_fd_pulse", i), 64'(s_fd_pre), 64'(vecs[i].exp_fd));
      chk($sformatf("v%0d_valid_n3", i), 64'(s_v_post), 64'd1);
      chk($sformatf("v%0d_data", i), 64'(s_data_post), 64'(vecs[i].exp_data));
      chk($sformatf("v%0d_idx", i), 64'(s_idx_post), 64'(vecs[i].exp_idx));
      chk($sformatf("v%0d_fd_end", i), 64'(s_fd_post), 64'd0);
    end

    // Two words per row on the WIDTH=4 instance
    do_reset();
    pulse_sync();
    send_word(16'h1122, -1);
    chk("w4_no_row_yet", 64'(s2_v_post), 64'd0);
    send_word(16'h3344, -1);
    chk("w4_valid", 64'(s2_v_post), 64'd1);
    chk("w4_data", 64'(s2_data_post), 64'h33441122);
    chk("w4_idx", 64'(s2_idx_post), 64'd0);

    // Downstream stalled for a whole frame
    do_reset();
    row_ready = 1'b0;
    pulse_sync();
    send_word(16'hA1B2, -1);
    send_word(16'hC3D4, -1);
    chk("stall_fd", 64'(s_fd_pre), 64'd1);
    chk("stall_valid", 64'(s_v_post), 64'd1);
    chk("stall_data", 64'(s_data_post), 64'hA1B2);
    chk("stall_idx", 64'(s_idx_post), 64'd0);
    chk("stall_ovf", 64'(s_ovf_post), 64'd1);
    pulse_clear();
    chk("stall_ovf_clr", 64'(overflow), 64'd0);
    chk("stall_still_held", 64'(row_data), 64'hA1B2);

    // Ready arrives in the same cycle row 1 is handed off
    do_reset();
    row_ready = 1'b0;
    pulse_sync();
    send_word(16'h0102, -1);
    send_word(16'h0304, 1);
    chk("same_cyc_valid", 64'(s_v_post), 64'd1);
    chk("same_cyc_data", 64'(s_data_post), 64'h0304);
    chk("same_cyc_idx", 64'(s_idx_post), 64'd1);
    chk("same_cyc_ovf", 64'(s_ovf_post), 64'd0);
    chk("same_cyc_drained", 64'(row_valid), 64'd0);

    // Early FRAME_SYNC, then strobes while waiting for sync
    do_reset();
    row_ready = 1'b1;
    pulse_sync();
    send_word(16'h1111, -1);
    pulse_sync();
    chk("ferr_set", 64'(frame_error), 64'd1);
    send_word(16'h2222, -1);
    chk("ferr_row_data", 64'(s_data_post), 64'h2222);
    chk("ferr_row_idx", 64'(s_idx_post), 64'd0);
    send_word(16'h3333, -1);
    chk("ferr_row1_idx", 64'(s_idx_post), 64'd1);
    send_word(16'h4444, -1);
    chk("idle_no_valid", 64'(s_v_post), 64'd0);
    chk("idle_data_kept", 64'(s_data_post), 64'h3333);
    pulse_clear();
    chk("ferr_clr", 64'(frame_error), 64'd0);
    pulse_sync();
    send_word(16'h5555, -1);
    err_clear = 1'b1;
    pulse_sync();
    err_clear = 1'b0;
    chk("ferr_beats_clear", 64'(frame_error), 64'd1);
    pulse_clear();
    chk("ferr_clr2", 64'(frame_error), 64'd0);

    // Reset in the middle of a row with flags and hold register set
    do_reset();
    row_ready = 1'b0;
    pulse_sync();
    send_word(16'h9999, -1);
    pulse_sync();
    send_word(16'hABCD, -1);
    chk("pre_rst_ovf", 64'(overflow), 64'd1);
    chk("pre_rst_ferr", 64'(frame_error), 64'd1);
    do_reset();
    chk("rst_valid", 64'(row_valid), 64'd0);
    chk("rst_data", 64'(row_data), 64'd0);
    chk("rst_idx", 64'(row_index), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_ferr", 64'(frame_error), 64'd0);
    chk("rst_fd", 64'(frame_done), 64'd0);
    chk("rst_w4_valid", 64'(row_valid2), 64'd0);
    chk("rst_w4_ferr", 64'(frame_error2), 64'd0);
    send_word(16'h0F0F, -1);
    chk("rst_wait_sync", 64'(s_v_post), 64'd0);
    chk("rst_wait_sync_w4", 64'(s2_v_post), 64'd0);
    row_ready = 1'b1;
    pulse_sync();
    send_word(16'h1122, -1);
    chk("post_rst_row0", 64'(s_data_post), 64'h1122);
    send_word(16'h3344, -1);
    chk("post_rst_row1", 64'(s_data_post), 64'h3344);
    chk("post_rst_w4_valid", 64'(s2_v_post), 64'd1);
    chk("post_rst_w4_data", 64'(s2_data_post), 64'h33441122);
    chk("post_rst_w4_idx", 64'(s2_idx_post), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_readout_receiver.md
Name: pixel_readout_receiver

Overview:
- Far end of the PIXEL_TOP readout interface: consumes the DATA_OUT_CLK / DATA_OUT word stream in the SYSTEM_CLK domain.
- Reassembles pixel words into complete rows and presents each row on a valid/ready handshake to downstream frame storage or processing.
- Tracks row and frame position, and flags dropped rows and truncated frames.

Parameters:
- WIDTH, 2, pixels per row
- HEIGHT, 2, rows per frame
- OUTPUT_BUS_PIXEL_WIDTH, 2, pixels per DATA_OUT word; must divide WIDTH
- BIT_DEPTH, 8, bits per pixel

Ports:
- SYSTEM_CLK  in  1  system clock; all logic on rising edge
- SYSTEM_RESET  in  1  synchronous, active-low reset
- DATA_OUT_CLK  in  1  word strobe from sensor; asynchronous to SYSTEM_CLK, rising edge marks a new word
- DATA_OUT  in  OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH  pixel word; pixel k at bits [k*BIT_DEPTH +: BIT_DEPTH]
- FRAME_SYNC  in  1  single-cycle pulse, SYSTEM_CLK domain; next word is pixel (row 0, col 0)
- ERR_CLEAR  in  1  clears the sticky error flags
- ROW_DATA  out  WIDTH*BIT_DEPTH  assembled row; column c at bits [c*BIT_DEPTH +: BIT_DEPTH]
- ROW_INDEX  out  max(1,$clog2(HEIGHT))  row number of ROW_DATA
- ROW_VALID  out  1  ROW_DATA/ROW_INDEX valid
- ROW_READY  in  1  downstream accepts row
- FRAME_DONE  out  1  one-cycle pulse when the last row of a frame is assembled
- OVERFLOW  out  1  sticky: row dropped because the hold buffer was occupied
- FRAME_ERROR  out  1  sticky: FRAME_SYNC arrived mid-frame

Behaviour:
- Reset (SYSTEM_RESET=0 at a clock edge, including mid-frame): all outputs 0, all counters 0, synchronizer flops 0, state WAIT_SYNC. Any partial row is discarded.
- Strobe synchronizer: 3-flop chain on DATA_OUT_CLK (s1, s2, s3) plus a 2-flop DATA_OUT pipeline aligned with s1/s2.
  - word_evt = s2 & ~s3; the captured word is the s2-aligned data.
  - Latency: rising edge of DATA_OUT_CLK sampled at edge N produces word_evt at edge N+2.
  - Sender contract: DATA_OUT stable ≥3 SYSTEM_CLK cycles around each strobe rise; strobe high and low phases ≥2 cycles each.
- Word placement:
  - WORDS_PER_ROW = WIDTH/OUTPUT_BUS_PIXEL_WIDTH.
  - On word_evt, pixel k of word w goes to assembly column w*OUTPUT_BUS_PIXEL_WIDTH+k.
- FSM states:
  - WAIT_SYNC: word_evt ignored. FRAME_SYNC -> RECEIVE, word_cnt=0, row_cnt=0.
  - RECEIVE: each word_evt writes into the assembly buffer and increments word_cnt.
    - On the last word of a row: word_cnt wraps to 0 and the row handoff occurs.
    - On the last word of row HEIGHT-1: FRAME_DONE pulses the following cycle and the FSM returns to WAIT_SYNC.
  - FRAME_SYNC in RECEIVE with word_cnt!=0 or row_cnt!=0: FRAME_ERROR=1, counters reset, stay in RECEIVE.
- Simultaneous FRAME_SYNC and word_evt: the sync takes effect first; that word is col 0, row 0 of the new frame.
- Row handoff (double buffer: assembly buffer + hold register):
  - Hold free (ROW_VALID=0, or ROW_VALID&ROW_READY in the same cycle): copy to hold on the next edge, set ROW_VALID=1 and ROW_INDEX=row_cnt. The same-cycle free case causes no overflow.
  - Hold occupied and not being accepted: new row dropped, OVERFLOW=1, row_cnt still advances.
- Handshake:
  - ROW_VALID stays high, and ROW_DATA/ROW_INDEX stay stable, until ROW_VALID&ROW_READY.
  - ROW_VALID does not depend combinationally on ROW_READY.
- Sticky flags:
  - ERR_CLEAR clears OVERFLOW and FRAME_ERROR.
  - A new error in the same cycle as ERR_CLEAR wins (flag stays 1).
- Width rules: word_cnt is $clog2(WORDS_PER_ROW) bits, minimum 1, and wraps only at WORDS_PER_ROW-1. row_cnt wraps at HEIGHT-1.

Decomposition:
- Package pixel_rx_pkg holds:
  - rx_state_t enum {WAIT_SYNC, RECEIVE}
  - localparam function words_per_row()
  - counter-width helper
- One sub-module: dout_clk_sync, the 3-flop strobe synchronizer with aligned data pipeline and word_evt output.
- Top module holds the FSM, counters, assembly buffer, hold register and flags.

Test Plan:
- Defaults (2x2, 1 word/row), ROW_READY=1: FRAME_SYNC, then words 0xA1B2, 0xC3D4 -> ROW_DATA=0xA1B2 with ROW_INDEX=0, then ROW_DATA=0xC3D4 with ROW_INDEX=1; FRAME_DONE single pulse; each ROW_VALID rises 3 cycles after its strobe rise.
- WIDTH=4, HEIGHT=2: words 0x1122, 0x3344 -> ROW_DATA=0x33441122 (col0=0x22, col3=0x33).
- ROW_READY=0 for a whole frame: row 0 held stable with ROW_INDEX=0; row 1 dropped; OVERFLOW=1; ERR_CLEAR -> OVERFLOW=0.
- ROW_READY asserted in the same cycle as row 1 completes -> row 1 transferred, OVERFLOW stays 0.
- Defaults, FRAME_SYNC after 1 of 2 rows -> FRAME_ERROR=1; the next row is reported with ROW_INDEX=0; strobes in WAIT_SYNC produce no ROW_VALID.
- SYSTEM_RESET=0 for one cycle mid-row -> all outputs 0, state WAIT_SYNC; the next frame after FRAME_SYNC assembles correctly.
